// File: rtl/reg_host_bridge.sv
// rtl/reg_host_bridge.sv - core req/gnt/rvalid port to single-cycle peripheral register strobes
module reg_host_bridge #(
  parameter int          AW        = 9,
  parameter int          DW        = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [31:0]     data_addr_i,
  input  logic [31:0]     data_wdata_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  output logic [31:0]     data_rdata_o,
  output logic            data_err_o,
  output logic            reg_we,
  output logic            reg_re,
  output logic [AW-1:0]   reg_addr,
  output logic [DW-1:0]   reg_wdata,
  output logic [DW/8-1:0] reg_be,
  input  logic [DW-1:0]   reg_rdata,
  input  logic            reg_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              decode_err;
  logic [AW-1:2]     addr_q;
  logic              we_q;
  logic [DW/8-1:0]   be_q;
  logic [DW-1:0]     wdata_q;
  logic              derr_q;
  logic [DW-1:0]     rdata_q;
  logic              err_q;

  // ACCESS is the only busy cycle; RESP can take a new request back-to-back
  assign data_gnt_o = data_req_i & (state != ACCESS);
  assign accept     = data_req_i & data_gnt_o;

  // Upper bits must hit the window exactly so out-of-window addresses never alias
  assign decode_err = (data_addr_i[31:AW] != BASE_ADDR[31:AW])
                    | (data_addr_i[1:0] != 2'b00)
                    | (data_we_i & (data_be_i == 4'b0000));

  // Register-side address/data/be mirror the captured request at all times
  assign reg_addr  = {addr_q, 2'b00};
  assign reg_be    = be_q;
  assign reg_wdata = wdata_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = accept ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: strobes only in ACCESS, response only in RESP
  always_comb begin
    reg_we        = 1'b0;
    reg_re        = 1'b0;
    data_rvalid_o = 1'b0;
    data_rdata_o  = 32'h0;
    data_err_o    = 1'b0;
    if (state == ACCESS && !derr_q) begin
      reg_we = we_q;
      reg_re = ~we_q;
    end
    if (state == RESP) begin
      data_rvalid_o = 1'b1;
      data_rdata_o  = rdata_q;
      data_err_o    = err_q;
    end
  end

  // Request capture in the accept cycle, including the decode verdict
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      derr_q  <= 1'b0;
    end else if (accept) begin
      addr_q  <= data_addr_i[AW-1:2];
      we_q    <= data_we_i;
      be_q    <= data_be_i;
      wdata_q <= data_wdata_i;
      derr_q  <= decode_err;
    end
  end

  // Response capture at the end of ACCESS; writes and errored reads return zero data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      rdata_q <= (~we_q & ~derr_q & ~reg_error) ? reg_rdata : '0;
      err_q   <= derr_q | reg_error;
    end
  end

endmodule

// File: tb/tb_reg_host_bridge.sv
// tb/tb_reg_host_bridge.sv - directed self-checking bench for reg_host_bridge
module tb_reg_host_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        reg_we;
  logic        reg_re;
  logic [8:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_error;

  int vectors = 0;
  int miscompares = 0;

  reg_host_bridge #(.AW(9), .DW(32), .BASE_ADDR(32'h4000_0000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_rdata(reg_rdata), .reg_error(reg_error)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns after that
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; data_req_i = 0; data_we_i = 0; data_be_i = 0;
    data_addr_i = 0; data_wdata_i = 0; reg_rdata = 0; reg_error = 0;
    #3;
    vectors++;
    if ({data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, reg_we, reg_re, reg_addr, reg_wdata, reg_be} !== 80'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%h err=%b we=%b re=%b a=%h wd=%h be=%h, need all 0",
               data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, reg_we, reg_re, reg_addr, reg_wdata, reg_be);
    end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  // One isolated transaction starting from IDLE, checked at T, T+1, T+2, T+3
  task automatic do_txn(input string nm, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd,
                        input logic perr, input logic [8:0] exp_ra, input logic exp_strobe,
                        input logic [31:0] exp_rd, input logic exp_err);
    logic [1:0] exp_st;
    exp_st = exp_strobe ? (we ? 2'b10 : 2'b01) : 2'b00;
    data_req_i = 1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wd;
    #1;
    vectors++;
    if ({data_gnt_o, reg_we, reg_re, data_rvalid_o} !== 4'b1000) begin
      miscompares++;
      $display("FAIL %s_T: got gnt/we/re/rv=%b, need 1000", nm, {data_gnt_o, reg_we, reg_re, data_rvalid_o});
    end
    tick();
    data_req_i = 0; reg_rdata = rd; reg_error = perr;
    #1;
    vectors++;
    if ({data_gnt_o, reg_we, reg_re, data_rvalid_o, reg_addr, reg_be, reg_wdata} !== {1'b0, exp_st, 1'b0, exp_ra, be, wd}) begin
      miscompares++;
      $display("FAIL %s_T1: got gnt=%b we=%b re=%b rv=%b a=%h be=%h wd=%h, need gnt=0 we/re=%b rv=0 a=%h be=%h wd=%h",
               nm, data_gnt_o, reg_we, reg_re, data_rvalid_o, reg_addr, reg_be, reg_wdata, exp_st, exp_ra, be, wd);
    end
    tick();
    reg_rdata = 32'h0; reg_error = 0;
    #1;
    vectors++;
    if ({data_rvalid_o, data_rdata_o, data_err_o, reg_we, reg_re} !== {1'b1, exp_rd, exp_err, 2'b00}) begin
      miscompares++;
      $display("FAIL %s_T2: got rv=%b rd=%h err=%b we=%b re=%b, need rv=1 rd=%h err=%b we=0 re=0",
               nm, data_rvalid_o, data_rdata_o, data_err_o, reg_we, reg_re, exp_rd, exp_err);
    end
    tick();
    #1;
    vectors++;
    if ({data_rvalid_o, data_rdata_o, data_err_o, reg_we, reg_re} !== 36'h0) begin
      miscompares++;
      $display("FAIL %s_T3: got rv=%b rd=%h err=%b we=%b re=%b, need all 0",
               nm, data_rvalid_o, data_rdata_o, data_err_o, reg_we, reg_re);
    end
    tick();
  endtask

  task automatic test_read();
    do_txn("read", 0, 32'h4000_010C, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 9'h10C, 1, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_write();
    do_txn("write", 1, 32'h4000_0110, 4'h3, 32'h0000_0001, 32'hCAFE_F00D, 0, 9'h110, 1, 32'h0, 0);
  endtask

  task automatic test_decode_errors();
    do_txn("out_of_window", 0, 32'h4000_0200, 4'hF, 32'h0, 32'h1234_5678, 0, 9'h000, 0, 32'h0, 1);
    do_txn("misaligned", 0, 32'h4000_0102, 4'hF, 32'h0, 32'h1234_5678, 0, 9'h100, 0, 32'h0, 1);
    do_txn("write_be0", 1, 32'h4000_0004, 4'h0, 32'hA5A5_A5A5, 32'h0, 0, 9'h004, 0, 32'h0, 1);
    do_txn("wrap_high", 0, 32'h5000_010C, 4'hF, 32'h0, 32'h1111_1111, 0, 9'h10C, 0, 32'h0, 1);
  endtask

  task automatic test_periph_error();
    do_txn("periph_err", 0, 32'h4000_0008, 4'hF, 32'h0, 32'h7777_7777, 1, 9'h008, 1, 32'h0, 1);
  endtask

  task automatic test_back_to_back();
    // T: first read offered and granted
    data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h4000_0020;
    #1;
    vectors++;
    if (data_gnt_o !== 1'b1) begin
      miscompares++; $display("FAIL b2b_gnt_T: got %b, need 1", data_gnt_o);
    end
    tick();
    // T+1: second read pending, first in ACCESS
    data_addr_i = 32'h4000_0024; reg_rdata = 32'hAAAA_0001;
    #1;
    vectors++;
    if ({data_gnt_o, reg_re, reg_addr, data_rvalid_o} !== {1'b0, 1'b1, 9'h020, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_T1: got gnt=%b re=%b a=%h rv=%b, need 0 1 020 0", data_gnt_o, reg_re, reg_addr, data_rvalid_o);
    end
    tick();
    #1;
    vectors++;
    if ({data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, reg_re} !== {2'b11, 32'hAAAA_0001, 2'b00}) begin
      miscompares++;
      $display("FAIL b2b_T2: got gnt=%b rv=%b rd=%h err=%b re=%b, need 1 1 aaaa0001 0 0",
               data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, reg_re);
    end
    tick();
    data_addr_i = 32'h4000_0028; reg_rdata = 32'hAAAA_0002;
    #1;
    vectors++;
    if ({data_gnt_o, reg_re, reg_addr, data_rvalid_o} !== {1'b0, 1'b1, 9'h024, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_T3: got gnt=%b re=%b a=%h rv=%b, need 0 1 024 0", data_gnt_o, reg_re, reg_addr, data_rvalid_o);
    end
    tick();
    #1;
    vectors++;
    if ({data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o} !== {2'b11, 32'hAAAA_0002, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_T4: got gnt=%b rv=%b rd=%h err=%b, need 1 1 aaaa0002 0",
               data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o);
    end
    tick();
    data_req_i = 0; reg_rdata = 32'hAAAA_0003;
    #1;
    vectors++;
    if ({reg_re, reg_addr, data_rvalid_o} !== {1'b1, 9'h028, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_T5: got re=%b a=%h rv=%b, need 1 028 0", reg_re, reg_addr, data_rvalid_o);
    end
    tick();
    reg_rdata = 32'h0;
    #1;
    vectors++;
    if ({data_gnt_o, data_rvalid_o, data_rdata_o} !== {2'b01, 32'hAAAA_0003}) begin
      miscompares++;
      $display("FAIL b2b_T6: got gnt=%b rv=%b rd=%h, need 0 1 aaaa0003", data_gnt_o, data_rvalid_o, data_rdata_o);
    end
    tick();
    #1;
    vectors++;
    if (data_rvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL b2b_T7: got rv=%b, need 0", data_rvalid_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h4000_0030; data_wdata_i = 32'h0;
    tick();
    data_req_i = 0; reg_rdata = 32'hBBBB_BBBB;
    #1;
    vectors++;
    if (reg_re !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_access: got re=%b, need 1", reg_re);
    end
    #1;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, reg_we, reg_re, reg_addr, reg_wdata, reg_be} !== 80'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got rv=%b re=%b a=%h be=%h, need all 0", data_rvalid_o, reg_re, reg_addr, reg_be);
    end
    tick();
    rst_ni = 1'b1; reg_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({data_rvalid_o, reg_re, reg_we} !== 3'b000) begin
        miscompares++;
        $display("FAIL rst_mid_quiet%0d: got rv=%b re=%b we=%b, need 000", i, data_rvalid_o, reg_re, reg_we);
      end
    end
    tick();
    do_txn("after_rst", 0, 32'h4000_0034, 4'hF, 32'h0, 32'h0BAD_CAFE, 0, 9'h034, 1, 32'h0BAD_CAFE, 0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_decode_errors();
    test_periph_error();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_host_bridge.md
Name: reg_host_bridge

Overview:
- Bus initiator for the peripheral register interface (reg_we/reg_re/reg_addr/reg_wdata/reg_be -> reg_rdata/reg_error) used by rv_timer and sibling peripherals.
- Converts a core-side req/gnt/rvalid data port into single-cycle register strobes.
- Adds address-window decode and alignment checks, and returns the registered response.
- Sits between the core LSU crossbar port and one peripheral's register top.

Parameters:
- AW, 9, register address width on the peripheral side.
- DW, 32, data width; fixed at 32 in this revision.
- BASE_ADDR, 32'h4000_0000, window base; bits [AW-1:0] of BASE_ADDR are ignored.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- data_req_i  input  1  core request valid.
- data_we_i  input  1  1=write, 0=read.
- data_be_i  input  4  byte enables.
- data_addr_i  input  32  byte address.
- data_wdata_i  input  32  write data.
- data_gnt_o  output  1  request accepted this cycle.
- data_rvalid_o  output  1  response valid, one-cycle pulse.
- data_rdata_o  output  32  read data, valid with rvalid.
- data_err_o  output  1  error, valid with rvalid.
- reg_we  output  1  register write strobe.
- reg_re  output  1  register read strobe.
- reg_addr  output  AW  word-aligned register address.
- reg_wdata  output  DW  write data.
- reg_be  output  DW/8  byte enables.
- reg_rdata  input  DW  peripheral read data, combinational, same cycle as the strobe.
- reg_error  input  1  peripheral error, same cycle as the strobe.

Behaviour:
- Reset (async, rst_ni=0): state=IDLE. gnt, rvalid, err, reg_we and reg_re are 0. rdata, reg_addr, reg_wdata and reg_be are 0. Reset mid-transaction drops the transaction silently, with no rvalid.
- FSM states: IDLE, ACCESS, RESP.
- Grant: data_gnt_o = data_req_i & (state != ACCESS). gnt is combinational from req. A request is accepted in the cycle req&gnt.
- On accept (cycle T):
  - Register addr, we, be and wdata into request flops.
  - Compute decode_err = (addr[31:AW] != BASE_ADDR[31:AW]) | (addr[1:0] != 0) | (we & be==0).
  - Register decode_err. Next state = ACCESS.
- ACCESS (cycle T+1):
  - If decode_err=0: reg_we = we_q, reg_re = ~we_q. Strobe is high for exactly one cycle.
  - reg_addr = {addr_q[AW-1:2], 2'b00}; reg_be = be_q; reg_wdata = wdata_q.
  - If decode_err=1: no strobe. reg_* address, data and be outputs still hold request values.
  - Capture at the clock edge ending the cycle:
    - rdata_q = (read & no decode_err & ~reg_error) ? reg_rdata : 0.
    - err_q = decode_err | reg_error.
  - Next state = RESP.
- RESP (cycle T+2): data_rvalid_o=1, data_rdata_o=rdata_q, data_err_o=err_q.
  - Writes always return rdata=0.
  - If req&gnt in RESP: accept the new request, next state = ACCESS (back-to-back).
  - Else next state = IDLE.
- Outside RESP: rvalid=0. data_rdata_o and data_err_o are held at 0 when rvalid=0.
- Latency and throughput:
  - Fixed 2-cycle latency from gnt to rvalid.
  - At most one outstanding transaction.
  - Sustained throughput is one transaction per 2 cycles.
- Request signals must be held stable while req=1 and gnt=0. The bridge reads them only in the accept cycle.
- Register strobes are never asserted in IDLE or RESP. reg_we and reg_re are never both high.
- Address wrap: address bits at or above AW outside the window are an error. They never alias into the peripheral.

Test Plan:
- Read in window: req, we=0, addr=BASE+0x10C, be=4'hF; reg_rdata=32'hDEAD_BEEF during ACCESS. Expected: gnt at T; reg_re=1 and reg_addr=9'h10C at T+1; rvalid=1, rdata=32'hDEAD_BEEF, err=0 at T+2.
- Write in window: we=1, addr=BASE+0x110, wdata=32'h0000_0001, be=4'h3. Expected: reg_we=1 for exactly 1 cycle with reg_be=4'h3 and reg_wdata=1; rvalid at T+2 with rdata=0, err=0.
- Decode errors: addr=BASE+0x200 (AW=9, outside window); addr=BASE+0x102 (misaligned); write with be=0. Expected for each: no reg_we/reg_re pulse, rvalid at T+2 with err=1, rdata=0.
- Peripheral error: read with reg_error=1 during ACCESS. Expected: err=1, rdata=0 at T+2.
- Back-to-back: req held high for 3 reads. Expected: gnt at T, T+2, T+4; gnt=0 at T+1, T+3; rvalid at T+2, T+4, T+6 with matching data, in order.
- Reset mid-transaction: assert rst_ni=0 during ACCESS. Expected: all outputs 0 immediately (async); after release, no rvalid until a new request is granted.
